// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared
// combinational ALU. One operation at a time runs IDLE -> EXEC -> RESP.
// Operands are latched on accept. The ALU result is captured in EXEC and
// held in RESP until the owning requester takes the response.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // requester 0
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_err,
    // requester 1
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_err,
    // shared ALU
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    // status
    output logic              busy,
    output logic [15:0]       ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_next_s;

    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    logic [3:0]          ctrl_r;
    logic                idx_r;
    logic [DATA_W-1:0]   result_r;
    logic                zero_r;
    logic                err_r;
    logic                last_grant_r;
    logic [15:0]         ops_done_r;

    logic                grant_s;
    logic                accept_s;
    logic                rsp_fire_s;
    logic                ctrl_legal_s;

    // Only AND, OR, ADD, SUB and SLT are supported. Any other code is
    // reported as an error and the ALU output is discarded.
    function automatic logic ctrl_is_legal(input logic [3:0] ctrl);
        logic legal;
        case (ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

    assign ctrl_legal_s = ctrl_is_legal(ctrl_r);

    // Pick the requester to serve. On a tie the one not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Ready is offered only in IDLE and only to the granted requester.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_r == IDLE) begin
            req0_ready = req0_valid && !grant_s;
            req1_ready = req1_valid && grant_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    assign accept_s   = req0_ready || req1_ready;
    assign rsp_fire_s = (state_r == RESP) && (idx_r ? rsp1_ready : rsp0_ready);

    // Sequencing. EXEC always lasts exactly one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: state_next_s = RESP;
            RESP: begin
                if (rsp_fire_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register. Reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the operands and the owner of the granted request on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= {DATA_W{1'b0}};
            b_r    <= {DATA_W{1'b0}};
            ctrl_r <= 4'b0000;
            idx_r  <= 1'b0;
        end else if (accept_s) begin
            a_r    <= grant_s ? req1_a    : req0_a;
            b_r    <= grant_s ? req1_b    : req0_b;
            ctrl_r <= grant_s ? req1_ctrl : req0_ctrl;
            idx_r  <= grant_s;
        end
    end

    // Capture the ALU outputs in EXEC, or force an error for an illegal code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {DATA_W{1'b0}};
            zero_r   <= 1'b0;
            err_r    <= 1'b0;
        end else if (state_r == EXEC) begin
            if (ctrl_legal_s) begin
                result_r <= alu_result;
                zero_r   <= alu_zero;
                err_r    <= 1'b0;
            end else begin
                result_r <= {DATA_W{1'b0}};
                zero_r   <= 1'b0;
                err_r    <= 1'b1;
            end
        end
    end

    // Record the completed owner for round-robin and count completions.
    // Starting last_grant at 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
            ops_done_r   <= 16'h0000;
        end else if (rsp_fire_s) begin
            last_grant_r <= idx_r;
            ops_done_r   <= ops_done_r + 16'h0001;
        end
    end

    assign alu_a    = a_r;
    assign alu_b    = b_r;
    assign alu_ctrl = ctrl_r;

    assign rsp0_valid  = (state_r == RESP) && !idx_r;
    assign rsp1_valid  = (state_r == RESP) &&  idx_r;
    assign rsp0_result = result_r;
    assign rsp1_result = result_r;
    assign rsp0_zero   = zero_r;
    assign rsp1_zero   = zero_r;
    assign rsp0_err    = err_r;
    assign rsp1_err    = err_r;

    assign busy     = (state_r == EXEC) || (state_r == RESP);
    assign ops_done = ops_done_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. It contains a behavioural model of the shared ALU
// and a scoreboard of expected responses in the expected service order.
module tb_alu_arbiter;
    localparam int DATA_W = 32;
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_BAD = 4'b1111;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_ctrl, req1_ctrl;
    logic rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [DATA_W-1:0] rsp0_result, rsp1_result;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_ctrl;
    logic alu_zero;
    logic busy;
    logic [15:0] ops_done;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .ops_done(ops_done)
    );

    // Shared ALU. An unsupported code yields garbage that the arbiter must ignore.
    always_comb begin
        alu_result = 32'h0000_0000;
        alu_zero   = 1'b0;
        case (alu_ctrl)
            C_AND: alu_result = alu_a & alu_b;
            C_OR:  alu_result = alu_a | alu_b;
            C_ADD: alu_result = alu_a + alu_b;
            C_SUB: alu_result = alu_a - alu_b;
            C_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'h0000_0000) || (alu_ctrl == C_BAD);
    end

    typedef struct {
        bit          idx;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   exp_ops = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input bit n, input logic [3:0] c,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.idx = n;
        e.err = 1'b0;
        case (c)
            C_AND: e.result = a & b;
            C_OR:  e.result = a | b;
            C_ADD: e.result = a + b;
            C_SUB: e.result = a - b;
            C_SLT: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                e.result = 32'd0;
                e.err    = 1'b1;
            end
        endcase
        e.zero = !e.err && (e.result == 32'd0);
        return e;
    endfunction

    task automatic push(input bit n, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        sb_q.push_back(model(n, c, a, b));
        exp_ops++;
    endtask

    task automatic set_req(input bit n, input logic v, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b);
        if (n == 1'b0) begin
            req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
        end
    endtask

    task automatic wait_ready(input bit n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (n ? req1_ready : req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Present one request, wait for acceptance, then drop valid.
    task automatic send(input bit n, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        @(posedge clk); #1;
        set_req(n, 1'b1, c, a, b);
        wait_ready(n, ok);
        check(n ? "accept1" : "accept0", ok, 1);
        @(posedge clk); #1;
        if (n == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, ok, 1);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
        check({tag, "_ops_done"}, ops_done, exp_ops);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req0_ready"}, req0_ready, 0);
        check({tag, "_req1_ready"}, req1_ready, 0);
        check({tag, "_rsp0_valid"}, rsp0_valid, 0);
        check({tag, "_rsp1_valid"}, rsp1_valid, 0);
        check({tag, "_rsp_zero"}, {rsp1_zero, rsp0_zero}, 0);
        check({tag, "_rsp_err"}, {rsp1_err, rsp0_err}, 0);
        check({tag, "_rsp0_result"}, rsp0_result, 0);
        check({tag, "_rsp1_result"}, rsp1_result, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_ctrl"}, alu_ctrl, 0);
        check({tag, "_ops_done"}, ops_done, 0);
    endtask

    // Cycle counter used for latency measurement.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor: latency from accept and scoreboard comparison.
    initial begin
        int   acc_cyc[2];
        bit   pend[2];
        logic [1:0] qv, qr, rv, rr;
        exp_t e;
        pend = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = '{1'b0, 1'b0};
            end else begin
                qv = {req1_valid, req0_valid};
                qr = {req1_ready, req0_ready};
                rv = {rsp1_valid, rsp0_valid};
                rr = {rsp1_ready, rsp0_ready};
                for (int n = 0; n < 2; n++) begin
                    if (qv[n] && qr[n]) begin
                        acc_cyc[n] = cyc;
                        pend[n]    = 1'b1;
                    end
                    if (rv[n] && pend[n]) begin
                        check($sformatf("latency%0d", n), cyc - acc_cyc[n], 2);
                        pend[n] = 1'b0;
                    end
                    if (rv[n] && rr[n]) begin
                        check($sformatf("rsp%0d_expected", n), sb_q.size() != 0, 1);
                        if (sb_q.size() != 0) begin
                            e = sb_q.pop_front();
                            check($sformatf("rsp%0d_order", n), n, e.idx);
                            check($sformatf("rsp%0d_result", n), n ? rsp1_result : rsp0_result, e.result);
                            check($sformatf("rsp%0d_zero", n), n ? rsp1_zero : rsp0_zero, e.zero);
                            check($sformatf("rsp%0d_err", n), n ? rsp1_err : rsp0_err, e.err);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        // Tie on the first cycle after reset: requester 0 first.
        push(1'b0, C_SUB, 32'd15, 32'd15);
        push(1'b1, C_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        fork
            send(1'b0, C_SUB, 32'd15, 32'd15);
            send(1'b1, C_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        join
        wait_drain("tie");

        // Both held valid for four operations: order 0,1,0,1.
        push(1'b0, C_ADD, 32'd100, 32'd23);
        push(1'b1, C_SLT, 32'hFFFF_FFFB, 32'd3);
        push(1'b0, C_SLT, 32'd20, 32'd10);
        push(1'b1, C_SUB, 32'd3, 32'd5);
        fork
            begin
                send(1'b0, C_ADD, 32'd100, 32'd23);
                send(1'b0, C_SLT, 32'd20, 32'd10);
            end
            begin
                send(1'b1, C_SLT, 32'hFFFF_FFFB, 32'd3);
                send(1'b1, C_SUB, 32'd3, 32'd5);
            end
        join
        wait_drain("rr");

        // Single requester ADD 10 + 5.
        push(1'b0, C_ADD, 32'd10, 32'd5);
        send(1'b0, C_ADD, 32'd10, 32'd5);
        wait_drain("add");

        // Illegal code, then a legal op clears the error.
        push(1'b0, C_BAD, 32'd1, 32'd2);
        push(1'b0, C_OR, 32'h0000_00F0, 32'h0000_000F);
        send(1'b0, C_BAD, 32'd1, 32'd2);
        send(1'b0, C_OR, 32'h0000_00F0, 32'h0000_000F);
        wait_drain("err");

        // Response back-pressure on requester 1 with requester 0 pending.
        rsp1_ready = 1'b0;
        push(1'b1, C_ADD, 32'd7, 32'd9);
        send(1'b1, C_ADD, 32'd7, 32'd9);
        push(1'b0, C_AND, 32'h0000_0003, 32'h0000_0006);
        set_req(1'b0, 1'b1, C_AND, 32'h0000_0003, 32'h0000_0006);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp1_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("stall_rsp1_seen", ok, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp1_valid", rsp1_valid, 1);
            check("stall_rsp1_result", rsp1_result, 32'd16);
            check("stall_ready", {req1_ready, req0_ready}, 0);
            check("stall_busy", busy, 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        wait_ready(1'b0, ok);
        check("stall_accept0", ok, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_drain("stall");

        // Reset during EXEC drops the operation.
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, C_OR, 32'hF000_0000, 32'h0000_000F);
        wait_ready(1'b0, ok);
        check("rst_accept0", ok, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check("rst_busy_exec", busy, 1);
        check("rst_alu_a_exec", alu_a, 32'hF000_0000);
        rst_n = 1'b0;
        #2;
        check_reset("rst_exec");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_rsp0", rsp0_valid, 0);
        end
        check_reset("rst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; all datapath ports below use DATA_W.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-003 req0_valid input 1, requester 0 operation valid; req0_ready output 1, requester 0 accepted.
REQ-004 req0_a input DATA_W, req0_b input DATA_W, req0_ctrl input 4: requester 0 operands and ALU control code.
REQ-005 rsp0_valid output 1; rsp0_ready input 1; rsp0_result output DATA_W; rsp0_zero output 1; rsp0_err output 1: requester 0 response.
REQ-006 req1_* and rsp1_* SHALL be identical in direction, width and meaning for requester 1.
REQ-007 alu_a output DATA_W, alu_b output DATA_W, alu_ctrl output 4: drive the shared combinational ALU; alu_result input DATA_W, alu_zero input 1: its outputs.
REQ-008 busy output 1, transaction in flight; ops_done output 16, completed-operation count.

Function
REQ-009 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-010 IDLE: reqN_ready = 1 only for the granted requester, combinationally from the valids; no ready outside IDLE.
REQ-011 Grant: single valid wins; both valid -> requester not granted last (round-robin via last_grant register).
REQ-012 On reqN_valid && reqN_ready: latch a, b, ctrl and the requester index into internal registers; IDLE -> EXEC.
REQ-013 alu_a, alu_b, alu_ctrl SHALL be driven from the latched registers in every state.
REQ-014 EXEC (exactly 1 cycle): capture alu_result and alu_zero into response registers; EXEC -> RESP.
REQ-015 Legal ctrl codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT; any other code -> result 0, zero 0, err 1, ALU output ignored.
REQ-016 RESP: rspN_valid = 1 only for the latched requester; result, zero and err held stable until rspN_ready.
REQ-017 RESP with rspN_ready = 1: last_grant <= N; ops_done += 1 (wraps 0xFFFF -> 0x0000); RESP -> IDLE.
REQ-018 Latency: accept at edge N -> rsp_valid asserted after edge N+2; minimum 3 cycles per operation.
REQ-019 busy = 1 in EXEC and RESP, 0 in IDLE.
REQ-020 A requester deasserting valid while not granted SHALL be allowed and SHALL leave no state change.
REQ-021 The non-granted requester's valid SHALL stay pending with no loss; it is granted at the next IDLE.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, clear operand/ctrl/response registers, ops_done = 0, and set last_grant = 1 (requester 0 wins the first tie).
REQ-023 Reset values: all ready/valid/err/zero/busy = 0; alu_a = alu_b = 0; alu_ctrl = 0000; rsp results = 0.
REQ-024 Reset in EXEC or RESP SHALL drop the transaction and produce no response after release.

Verification
REQ-025 req0 ADD a=10, b=5 alone, rsp0_ready = 1 -> rsp0_valid two cycles after accept; result 0x0000000F; zero 0; err 0; ops_done = 1.
REQ-026 First cycle after reset, both valid: req0 SUB 15,15 and req1 AND 0xF0F0F0F0,0x0F0F0F0F -> req0 served first (result 0, zero 1), then req1 (result 0, zero 1).
REQ-027 Both held valid for 4 ops -> grant order 0,1,0,1; req1 SLT a=-5, b=3 -> result 1; req0 SLT a=20, b=10 -> result 0, zero 1.
REQ-028 rsp1_ready low for 5 cycles in RESP -> rsp1_valid and rsp1_result stable; both req_ready 0; busy 1.
REQ-029 req0 ctrl 1111 -> rsp0_err 1, result 0, zero 0; the next legal op returns err 0.
REQ-030 rst_n low during EXEC of req0 OR 0xF0000000,0x0000000F -> no rsp0_valid after release; ops_done 0; all outputs at reset values.
